// File: rtl/dcache_ctrl_param_if.sv
// Bus bundles for the data cache: the MEM-stage request port and the block-wide memory port.
// Parameters must match those of the dcache_ctrl_param instance they connect to.
interface dcache_cpu_if #(
    parameter int ADDR_W = 32
);
    logic              READ_EN;
    logic              WRITE_EN;
    logic [ADDR_W-1:0] ADDRESS;
    logic [31:0]       WRITEDATA;
    logic [2:0]        FUNC3;
    logic [31:0]       READ_DATA;
    logic              BUSYWAIT;
    logic              MISALIGNED;

    modport master (
        output READ_EN, WRITE_EN, ADDRESS, WRITEDATA, FUNC3,
        input  READ_DATA, BUSYWAIT, MISALIGNED
    );
    modport slave (
        input  READ_EN, WRITE_EN, ADDRESS, WRITEDATA, FUNC3,
        output READ_DATA, BUSYWAIT, MISALIGNED
    );
endinterface

interface dcache_mem_if #(
    parameter int ADDR_W    = 32,
    parameter int WOFF_BITS = 2
);
    localparam int BLOCK_W = 32 << WOFF_BITS;
    localparam int MADDR_W = ADDR_W - 2 - WOFF_BITS;

    logic               MEM_READ;
    logic               MEM_WRITE;
    logic [MADDR_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0] MEM_WRITEDATA;
    logic [BLOCK_W-1:0] MEM_READDATA;
    logic               MEM_BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );
    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );
endinterface

// File: rtl/dcache_ctrl_param.sv
// Direct-mapped write-back, write-allocate data cache controller with byte-lane
// loads/stores, misalignment detection and a WRITEBACK/ALLOCATE miss FSM.
module dcache_ctrl_param #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 3,
    parameter int WOFF_BITS  = 2
) (
    input  logic         CLOCK,
    input  logic         RESET,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);
    localparam int BLOCK_W = 32 << WOFF_BITS;
    localparam int LINES   = 1 << INDEX_BITS;
    localparam int WORDS   = 1 << WOFF_BITS;
    localparam int TAG_W   = ADDR_W - 2 - WOFF_BITS - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state_reg, state_next;

    logic [1:0]            byte_off;
    logic [WOFF_BITS-1:0]  word_sel;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;

    assign byte_off = cpu.ADDRESS[1:0];
    assign word_sel = cpu.ADDRESS[WOFF_BITS+1:2];
    assign index    = cpu.ADDRESS[WOFF_BITS+2 +: INDEX_BITS];
    assign tag      = cpu.ADDRESS[ADDR_W-1 -: TAG_W];

    // Data and tags are read combinationally so a load hit returns in its own cycle.
    logic [BLOCK_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid_reg, dirty_reg;

    logic [INDEX_BITS-1:0] miss_index_reg;
    logic [TAG_W-1:0]      miss_tag_reg;

    logic req, idle, misaligned, hit, store_we, fill_we;

    assign req  = cpu.READ_EN | cpu.WRITE_EN;
    assign idle = (state_reg == IDLE);
    assign misaligned = req & (((cpu.FUNC3[1:0] == 2'b01) & cpu.ADDRESS[0]) |
                               (cpu.FUNC3[1] & (byte_off != 2'b00)));
    assign hit      = valid_reg[index] & (tag_mem[index] == tag);
    assign store_we = idle & cpu.WRITE_EN & hit & ~misaligned;
    assign fill_we  = (state_reg == ALLOCATE) & ~mem.MEM_BUSYWAIT;

    logic [BLOCK_W-1:0] cur_line, new_line;
    logic [31:0]        line_words [WORDS];
    logic [31:0]        cur_word, merged_word, lane_data;
    logic [3:0]         byte_en;

    assign cur_line = data_mem[index];
    assign cur_word = line_words[word_sel];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign line_words[gi] = cur_line[32*gi +: 32];
            assign new_line[32*gi +: 32] =
                (word_sel == WOFF_BITS'(gi)) ? merged_word : line_words[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_lanes
            assign merged_word[8*gi +: 8] =
                byte_en[gi] ? lane_data[8*gi +: 8] : cur_word[8*gi +: 8];
        end
    endgenerate

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en   = 4'b1111;
        lane_data = cpu.WRITEDATA;
        case (cpu.FUNC3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << byte_off;
                lane_data = {4{cpu.WRITEDATA[7:0]}};
            end
            2'b01: begin
                byte_en   = cpu.ADDRESS[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cpu.WRITEDATA[15:0]}};
            end
            default: ;
        endcase
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    always_comb begin
        case (byte_off)
            2'd0:    sel_byte = cur_word[7:0];
            2'd1:    sel_byte = cur_word[15:8];
            2'd2:    sel_byte = cur_word[23:16];
            default: sel_byte = cur_word[31:24];
        endcase
        sel_half = cpu.ADDRESS[1] ? cur_word[31:16] : cur_word[15:0];
        case (cpu.FUNC3)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = cur_word;
        endcase
    end

    // Data array and tags carry no reset; only valid/dirty are cleared.
    always_ff @(posedge CLOCK) begin
        if (fill_we) begin
            data_mem[miss_index_reg] <= mem.MEM_READDATA;
            tag_mem[miss_index_reg]  <= miss_tag_reg;
        end else if (store_we) begin
            data_mem[index] <= new_line;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (fill_we) begin
            valid_reg[miss_index_reg] <= 1'b1;
            dirty_reg[miss_index_reg] <= 1'b0;
        end else if (store_we) begin
            dirty_reg[index] <= 1'b1;
        end
    end

    // The missing line is latched so a request that drops mid-miss still fills correctly.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            miss_index_reg <= '0;
            miss_tag_reg   <= '0;
        end else if (idle && state_next != IDLE) begin
            miss_index_reg <= index;
            miss_tag_reg   <= tag;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req && !misaligned && !hit)
                    state_next = dirty_reg[index] ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: if (!mem.MEM_BUSYWAIT) state_next = ALLOCATE;
            ALLOCATE:  if (!mem.MEM_BUSYWAIT) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem.MEM_READ      = 1'b0;
        mem.MEM_WRITE     = 1'b0;
        mem.MEM_ADDRESS   = '0;
        mem.MEM_WRITEDATA = '0;
        cpu.BUSYWAIT      = ~idle | (req & ~hit & ~misaligned);
        cpu.MISALIGNED    = misaligned;
        cpu.READ_DATA     = (idle & req & hit & ~misaligned) ? load_ext : 32'd0;
        case (state_reg)
            WRITEBACK: begin
                mem.MEM_WRITE     = 1'b1;
                mem.MEM_ADDRESS   = {tag_mem[miss_index_reg], miss_index_reg};
                mem.MEM_WRITEDATA = data_mem[miss_index_reg];
            end
            ALLOCATE: begin
                mem.MEM_READ    = 1'b1;
                mem.MEM_ADDRESS = {miss_tag_reg, miss_index_reg};
            end
            default: ;
        endcase
    end
endmodule

// File: doc/dcache_ctrl_param.md
Name: dcache_ctrl_param

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache controller for the RV32IM pipeline MEM stage.
- Generalises the previous controller in three ways:
  - Configurable line count and block size.
  - True byte-lane stores and loads at ADDRESS[1:0] offsets, with sign/zero extension.
  - A misalignment flag.
- Sits between the MEM stage and the block-wide data memory. Owns tag, valid and dirty arrays and the miss FSM.

Parameters:
- ADDR_W, 32, byte address width.
- INDEX_BITS, 3, log2(number of lines); 8 lines by default.
- WOFF_BITS, 2, log2(words per block); 4 words, so BLOCK_W = 32<<WOFF_BITS = 128.

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- READ_EN  in  1  load request.
- WRITE_EN  in  1  store request.
- ADDRESS  in  ADDR_W  byte address (ALU result).
- WRITEDATA  in  32  store data (rs2).
- FUNC3  in  3  RISC-V load/store funct3.
- READ_DATA  out  32  extended load result.
- BUSYWAIT  out  1  stall pipeline.
- MISALIGNED  out  1  access not naturally aligned.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block writeback request.
- MEM_ADDRESS  out  ADDR_W-2-WOFF_BITS  block address.
- MEM_WRITEDATA  out  BLOCK_W  victim block.
- MEM_READDATA  in  BLOCK_W  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; asserted combinationally in the same cycle a request is raised.

Behaviour:
- Address split: byte = ADDRESS[1:0]; word = ADDRESS[WOFF_BITS+1:2]; index = next INDEX_BITS; tag = remaining upper bits.
- Request: req = READ_EN | WRITE_EN. If both are high, the request is a store.
- Misaligned:
  - Definition: FUNC3[1:0]=01 with ADDRESS[0]=1, or FUNC3[1:0]=1x with ADDRESS[1:0]!=0.
  - Response: MISALIGNED=1 combinationally; no cache or memory access; BUSYWAIT=0; READ_DATA=0.
- Hit: hit = valid[index] & tag match, evaluated combinationally.
  - Load hit: READ_DATA valid in the same cycle; BUSYWAIT=0; zero added latency.
  - Store hit: the addressed lane is written at the next rising edge and dirty[index] is set. BUSYWAIT=0.
- Load extraction:
  - 000 lb: byte at offset ADDRESS[1:0], sign-extended.
  - 100 lbu: same byte, zero-extended.
  - 001 lh: half at ADDRESS[1], sign-extended.
  - 101 lhu: same half, zero-extended.
  - 010, 011, 110, 111: full word.
- Store lanes:
  - FUNC3[1:0]=00: write WRITEDATA[7:0] into byte ADDRESS[1:0] only.
  - 01: write WRITEDATA[15:0] into half ADDRESS[1] only.
  - 1x: write the full word.
  - Other bytes of the word and block are untouched.
- Miss: BUSYWAIT=1 combinationally while req & !hit & !MISALIGNED, and whenever state != IDLE.
- FSM states IDLE, WRITEBACK, ALLOCATE:
  - IDLE -> WRITEBACK on a miss with dirty[index]=1.
  - IDLE -> ALLOCATE on a miss with a clean or invalid line.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=line data. Go to ALLOCATE at the first rising edge with MEM_BUSYWAIT=0.
  - ALLOCATE: MEM_READ=1, MEM_ADDRESS={request tag, index}. At the first rising edge with MEM_BUSYWAIT=0, write MEM_READDATA into the line, set valid=1, dirty=0, load the tag, and go to IDLE.
  - Back in IDLE, the held request re-evaluates as a hit. A store merges in that cycle and sets dirty.
- Miss latency: (wb ? Twb+1 : 0) + Tfetch+1 cycles plus the hit cycle.
- Request inputs must be held stable by the pipeline while BUSYWAIT=1. A request that drops mid-miss still completes the fill.
- MEM_READ and MEM_WRITE are never both 1. Both are 0 in IDLE.
- Reset (RESET=0, asynchronous), including mid-miss:
  - State goes to IDLE; all valid and dirty bits clear.
  - MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0 (absent a request), MISALIGNED=0 (absent a request), READ_DATA=0.
  - Any in-flight memory transaction is abandoned and the data array is not cleared.

Test Plan:
- After reset, lw 0x0000_0040 -> BUSYWAIT=1; single MEM_READ to block addr 0x4; no MEM_WRITE; then hit returns word 0 of MEM_READDATA. A repeat lw 0x40 gives BUSYWAIT=0 in the same cycle.
- Line holds 0x8899AABB at word 0x44:
  - sb 0x7F to 0x45 -> subsequent lw 0x44 = 0x88997FBB.
  - lb 0x46 = 0xFFFFFF99.
  - lbu 0x46 = 0x00000099.
  - lhu 0x46 = 0x00008899.
  - lh 0x44 = 0x00007FBB.
- Dirty line at index 4 (tag A); lw to the same index with tag B -> MEM_WRITE with {A,4} and the modified block, then MEM_READ with {B,4}; dirty clears after fill.
- lw 0x42 and sh 0x41 -> MISALIGNED=1, BUSYWAIT=0, no MEM_READ or MEM_WRITE, cache contents unchanged.
- Assert RESET=0 during ALLOCATE with MEM_BUSYWAIT=1 -> MEM_READ drops immediately. Next lw to the same address misses again.
- READ_EN=WRITE_EN=1 sw 0x12345678 at 0x80 (hit) -> treated as a store; subsequent lw 0x80 = 0x12345678.
